// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (LSB first, 1 start, 8 data, 1 stop, no parity).
// rxd is synchronized through two flops; each good frame produces a one-cycle
// rx_ready strobe with rdata. A bad stop bit sets the sticky ferr flag and the
// receiver waits for the line to return high before hunting for a new start.
// Optional macro UART_RX_MAJORITY_EN: start/data/stop decisions use a 2-of-3
// majority around mid-bit, taken one clock later than the single-sample build.
module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 1041
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_ready,
    output logic       ferr
);

    localparam int FULL = 2 * CLK_PER_HALF_BIT;
    localparam int CW   = $clog2(FULL);
`ifdef UART_RX_MAJORITY_EN
    // Decide at mid+1 so samples mid-1, mid, mid+1 are all available.
    localparam int START_SAMP = CLK_PER_HALF_BIT;
`else
    localparam int START_SAMP = CLK_PER_HALF_BIT - 1;
`endif
    localparam logic [CW-1:0] C_START = CW'(START_SAMP);
    localparam logic [CW-1:0] C_FULL  = CW'(FULL - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [2:0]      r_idx, w_idx;
    logic [7:0]      r_shift, w_shift;
    logic [7:0]      r_rdata, w_rdata;
    logic            r_rx_ready, w_rx_ready;
    logic            r_ferr, w_ferr;
    logic            r_rxd_m, r_rxd_s;
    logic            w_bit;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rxd_m <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_rxd_m <= rxd;
            r_rxd_s <= r_rxd_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two previous synchronized samples for the majority vote.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_hist <= 2'b11;
        else       r_hist <= {r_hist[0], r_rxd_s};
    end

    assign w_bit = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_rxd_s) | (r_hist[1] & r_rxd_s);
`else
    assign w_bit = r_rxd_s;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_rdata    <= '0;
            r_rx_ready <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_shift    <= w_shift;
            r_rdata    <= w_rdata;
            r_rx_ready <= w_rx_ready;
            r_ferr     <= w_ferr;
        end
    end

    // Next-state and datapath decisions; all timing is from the bit counter.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_shift    = r_shift;
        w_rdata    = r_rdata;
        w_rx_ready = 1'b0;
        w_ferr     = r_ferr;
        case (r_state)
            S_IDLE: begin
                if (!r_rxd_s) begin
                    w_cnt   = '0;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (r_cnt == C_START) begin
                    w_cnt = '0;
                    w_idx = '0;
                    // A high start sample is a glitch: drop back silently.
                    w_state = w_bit ? S_IDLE : S_DATA;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == C_FULL) begin
                    w_cnt   = '0;
                    w_shift = {w_bit, r_shift[7:1]};
                    w_idx   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == C_FULL) begin
                    w_cnt = '0;
                    if (w_bit) begin
                        // Leave at mid stop bit so a back-to-back start is caught.
                        w_rdata    = r_shift;
                        w_rx_ready = 1'b1;
                        w_ferr     = 1'b0;
                        w_state    = S_IDLE;
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = S_BREAK;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_BREAK: begin
                if (r_rxd_s) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign rdata    = r_rdata;
    assign rx_ready = r_rx_ready;
    assign ferr     = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with a reduced bit period.
// A negedge monitor logs every rx_ready pulse (data and cycle) for checking.
module tb_uart_rx;

    localparam int H   = 16;
    localparam int BIT = 2 * H;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int MAJ = 0;
    localparam logic [7:0] GLITCH_EXP = 8'h01;
`endif
    // 2 sync clocks + IDLE detect + 9.5 bits of counting, +1 with majority.
    localparam int LAT = 19 * H + 3 + MAJ;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rdata;
    logic       rx_ready;
    logic       ferr;

    uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .rdata    (rdata),
        .rx_ready (rx_ready),
        .ferr     (ferr)
    );

    always #25 clk = ~clk;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         wide = 0;
    int         t_start = 0;
    logic       prev_rdy = 1'b0;
    logic       ferr_seen = 1'b0;
    logic [7:0] q_data[$];
    int         q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log strobes, flag any pulse longer than one cycle, remember ferr.
    always @(negedge clk) begin
        if (rx_ready) begin
            q_data.push_back(rdata);
            q_cyc.push_back(cyc);
            if (prev_rdy) wide = wide + 1;
        end
        if (ferr) ferr_seen = 1'b1;
        prev_rdy = rx_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one frame starting at the current negedge. glitch_bit inverts that
    // data bit for one clock at its midpoint; rst_bit pulses rstn for 3 clocks
    // at mid-bit and abandons the rest of the frame (line returns to idle).
    task automatic send(input logic [7:0] d, input logic stop_v,
                        input int glitch_bit, input int rst_bit);
        rxd = 1'b0;
        t_start = cyc;
        repeat (BIT) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rxd = d[b];
            if (b == glitch_bit) begin
                repeat (H) @(negedge clk);
                rxd = ~d[b];
                @(negedge clk);
                rxd = d[b];
                repeat (H - 1) @(negedge clk);
            end else if (b == rst_bit) begin
                repeat (H) @(negedge clk);
                rstn = 1'b0;
                @(negedge clk);
                chk("rst_rdata", rdata, 8'h00);
                chk("rst_ready", rx_ready, 1'b0);
                chk("rst_ferr", ferr, 1'b0);
                repeat (2) @(negedge clk);
                rstn = 1'b1;
                rxd  = 1'b1;
                return;
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        rxd = stop_v;
        repeat (BIT) @(negedge clk);
    endtask

    string s = "The quick brown fox jumps over the lazy dog";
    int    base;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_ready", rx_ready, 1'b0);
        chk("reset_ferr", ferr, 1'b0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // 'T': single pulse, exact latency, one clock wide
        send(8'h54, 1'b1, -1, -1);
        repeat (BIT) @(negedge clk);
        chk("T_count", q_data.size(), 1);
        if (q_data.size() >= 1) begin
            chk("T_data", q_data[0], 8'h54);
            chk("T_latency", q_cyc[0] - t_start, LAT);
        end
        chk("T_width", wide, 0);
        chk("T_ferr", ferr, 1'b0);

        // 10-clock low glitch must be rejected, then 0x41 received
        base = q_data.size();
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("glitch_none", q_data.size(), base);
        chk("glitch_ferr", ferr, 1'b0);
        send(8'h41, 1'b1, -1, -1);
        repeat (BIT) @(negedge clk);
        chk("A_count", q_data.size(), base + 1);
        chk("A_rdata", rdata, 8'h41);

        // Bad stop bit + break: ferr set, no byte, rdata held
        base = q_data.size();
        send(8'hA5, 1'b0, -1, -1);
        repeat (2 * BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("brk_ferr", ferr, 1'b1);
        chk("brk_none", q_data.size(), base);
        chk("brk_rdata", rdata, 8'h41);
        send(8'h55, 1'b1, -1, -1);
        repeat (BIT) @(negedge clk);
        chk("U_count", q_data.size(), base + 1);
        chk("U_rdata", rdata, 8'h55);
        chk("U_ferr", ferr, 1'b0);

        // Back-to-back string with zero idle time
        base = q_data.size();
        ferr_seen = 1'b0;
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, -1, -1);
        repeat (BIT) @(negedge clk);
        chk("str_count", q_data.size(), base + 43);
        for (int i = 0; i < s.len(); i++)
            if (base + i < q_data.size()) chk("str_char", q_data[base + i], s[i]);
        chk("str_ferr", ferr_seen, 1'b0);
        chk("str_width", wide, 0);

        // Reset in data bit 4 of 0x33: no byte; 0xC3 received afterwards
        base = q_data.size();
        send(8'h33, 1'b1, -1, 4);
        repeat (2 * BIT) @(negedge clk);
        chk("rst_none", q_data.size(), base);
        chk("rst_hold", rdata, 8'h00);
        send(8'hC3, 1'b1, -1, -1);
        repeat (BIT) @(negedge clk);
        chk("C3_count", q_data.size(), base + 1);
        chk("C3_rdata", rdata, 8'hC3);

        // One-clock inversion at mid data bit 0 of 0x00
        base = q_data.size();
        send(8'h00, 1'b1, 0, -1);
        repeat (BIT) @(negedge clk);
        chk("mid_count", q_data.size(), base + 1);
        chk("mid_rdata", rdata, GLITCH_EXP);
        chk("mid_ferr", ferr, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver: LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity.
- Samples the external RX pin and delivers each received byte as a one-cycle strobe with data.
- Sits directly upstream of the byte-level logic inside the UART loopback path; its rdata/rx_ready pair feeds the transmit side.
- Bit timing is identical to the rest of the UART: 2*CLK_PER_HALF_BIT clocks per bit.

Parameters:
- CLK_PER_HALF_BIT, 1041: system clocks per half bit period (20 MHz clock, 9600 bps). Legal range is 4 or more.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, asynchronous to clk, idle high.
- rdata  output  8  last correctly received byte.
- rx_ready  output  1  one-cycle pulse; rdata is valid in the same cycle.
- ferr  output  1  framing error flag (sticky until the next good frame).

Behaviour:
- Reset values: rdata=8'h00, rx_ready=0, ferr=0, state=IDLE, counters=0, synchronizer flops=1.
- Synchronizer: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only.
- Bit counter width is $clog2(2*CLK_PER_HALF_BIT). The data-bit index is 3 bits.
- IDLE: when rxd_s==0, clear the counter and go to START.
- START: count CLK_PER_HALF_BIT-1 clocks (mid start bit), then sample.
  - rxd_s==0: clear the counter and index, go to DATA.
  - rxd_s==1: glitch; go to IDLE with no outputs changed.
- DATA: every 2*CLK_PER_HALF_BIT clocks, sample rxd_s at mid-bit and shift it into the shift register MSB side, so it ends LSB first. After the 8th sample go to STOP.
- STOP: after 2*CLK_PER_HALF_BIT clocks, sample at mid stop bit.
  - rxd_s==1: rdata<=shift register, rx_ready=1 for exactly 1 cycle, ferr<=0, go to IDLE.
  - rxd_s==0: ferr<=1, rdata unchanged, no rx_ready, go to BREAK.
- BREAK: wait for rxd_s==1, then go to IDLE. A held-low line (break) never produces a byte.
- Returning to IDLE at mid stop bit is required so that back-to-back frames with zero idle time are received.
- Latency: the rx_ready rising edge occurs 9.5 bit times +2..4 clk after the rxd start-bit falling edge.
- rx_ready has no back-pressure. The consumer takes rdata in the pulse cycle; rdata is held until the next good frame.
- rstn asserted mid-frame: immediate return to reset values. The partial byte is discarded. After release, reception resumes at the next falling edge seen in IDLE. If the line is low at release, the block enters START and rejects the frame unless it is a valid frame.
- Tolerance: correct reception with up to ±2% baud mismatch.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each start, data and stop decision is the 2-of-3 majority of rxd_s at counter values mid-1, mid and mid+1. The decision is taken at mid+1, so latency grows by 1 clk. Single-clock glitches at the sample point are rejected.
- Undefined: a single sample at mid, as described above.

Test Plan:
- Send byte 'T' (0x54) at TMBIT=104166 ns on a 20 MHz clock -> one rx_ready pulse, exactly 1 clk wide; rdata=8'h54; ferr=0; pulse about 9.5 bit times after the start edge.
- Drive rxd low for 10 clk, then high -> no rx_ready, ferr=0, FSM back in IDLE; a following 0x41 frame is received correctly.
- Frame 0xA5 with stop bit forced to 0, line held low 3 bit times, then high -> ferr=1, no rx_ready, rdata unchanged. The next frame 0x55 -> rx_ready, rdata=8'h55, ferr=0.
- Send "The quick brown fox jumps over the lazy dog" with zero idle time between frames -> 43 rx_ready pulses whose rdata sequence matches the string; ferr never set.
- Assert rstn low for 3 clk in the middle of data bit 4 of frame 0x33 -> outputs return to reset values, no rx_ready for that frame; the next frame 0xC3 is received correctly.
- With UART_RX_MAJORITY_EN, a 1-clk inverted glitch exactly at mid data bit 0 of 0x00 -> rdata=8'h00. Without the macro, the same stimulus -> rdata=8'h01.
